pmem_responder: RTL and testbench

//  Memory-side responder for the NPC data port. Accepts one load/store request at a time over a

---
 rtl/pmem_responder_if.sv | 42 ++++
 rtl/pmem_responder.sv | 149 ++++++++++++++
 tb/tb_pmem_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_responder_if.sv
// pmem_responder_if
//   Bundles the NPC data-port handshake and the physical-memory access port.
//   Request channel  : Req_Valid/Req_Ready, Req_Write, Req_Size, Req_Addr, Req_WData
//   Response channel : Resp_Valid/Resp_Ready, Resp_RData, Resp_Err
//   Memory port      : pmem_en (one-cycle access strobe), pmem_we, pmem_addr (8-byte aligned),
//                      pmem_wdata (lane-shifted), pmem_wmask (byte enables), pmem_rdata (combinational
//                      return of the aligned 8-byte word)
//   Modports: master (MEM stage), slave (responder), mem (physical-memory model)
interface pmem_responder_if;
   logic        Req_Valid;
   logic        Req_Ready;
   logic        Req_Write;
   logic [1:0]  Req_Size;
   logic [63:0] Req_Addr;
   logic [63:0] Req_WData;
   logic        Resp_Valid;
   logic        Resp_Ready;
   logic [63:0] Resp_RData;
   logic        Resp_Err;
   logic        pmem_en;
   logic        pmem_we;
   logic [63:0] pmem_addr;
   logic [63:0] pmem_wdata;
   logic [7:0]  pmem_wmask;
   logic [63:0] pmem_rdata;

   modport master (
      output Req_Valid, Req_Write, Req_Size, Req_Addr, Req_WData, Resp_Ready,
      input  Req_Ready, Resp_Valid, Resp_RData, Resp_Err
   );

   modport slave (
      input  Req_Valid, Req_Write, Req_Size, Req_Addr, Req_WData, Resp_Ready, pmem_rdata,
      output Req_Ready, Resp_Valid, Resp_RData, Resp_Err,
             pmem_en, pmem_we, pmem_addr, pmem_wdata, pmem_wmask
   );

   modport mem (
      input  pmem_en, pmem_we, pmem_addr, pmem_wdata, pmem_wmask,
      output pmem_rdata
   );
endinterface

// File: rtl/pmem_responder.sv
// pmem_responder
//   Memory-side responder for the NPC data port. Accepts one load/store at a time, waits
//   LATENCY cycles, performs the memory access exactly once, then holds the response until
//   it is consumed. Misaligned or out-of-window requests return Err=1, RData=0, no access.
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pmem_responder_if.slave (request/response channels + memory access port)
// Parameters
//   LATENCY   : accept edge to Resp_Valid rise, 1..15
//   ADDR_BASE : first legal byte address
//   ADDR_SIZE : legal window size in bytes
// Build option
//   RANDOM_DELAY_EN : adds 0..7 cycles of LFSR-derived extra latency per request
module pmem_responder #(
   parameter int unsigned LATENCY   = 2,
   parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
   parameter logic [63:0] ADDR_SIZE = 64'h0800_0000
) (
   input logic             clk,
   input logic             rst_n,
   pmem_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic        wr_q;
   logic [1:0]  size_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic        err_q;
   logic        resp_valid_q;
   logic [63:0] resp_rdata_q;
   logic        resp_err_q;

   // Request error check, evaluated on the incoming request at accept time.
   logic [3:0]  req_bytes;
   logic [64:0] req_end;
   logic [64:0] win_end;
   logic        req_misalign;
   logic        req_oor;

   assign req_bytes    = 4'd1 << bus.Req_Size;
   assign req_end      = {1'b0, bus.Req_Addr} + {61'd0, req_bytes};
   assign win_end      = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};
   assign req_misalign = (bus.Req_Addr[3:0] & (req_bytes - 4'd1)) != 4'd0;
   assign req_oor      = (bus.Req_Addr < ADDR_BASE) || (req_end > win_end);

   logic [4:0] delay_load;
`ifdef RANDOM_DELAY_EN
   logic [7:0] lfsr;

   // Fibonacci form of x^8+x^6+x^5+x^4+1, free-running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 8'hA5;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign delay_load = 5'(LATENCY - 1) + {2'b00, lfsr[2:0]};
`else
   assign delay_load = 5'(LATENCY - 1);
`endif

   // Access path driven from the latched request.
   logic [3:0]  q_bytes;
   logic [2:0]  offset;
   logic [5:0]  shamt;
   logic [8:0]  lane_mask;
   logic [63:0] rd_shifted;
   logic [63:0] load_data;

   assign q_bytes    = 4'd1 << size_q;
   assign offset     = addr_q[2:0];
   assign shamt      = {offset, 3'b000};
   assign lane_mask  = (9'd1 << q_bytes) - 9'd1;
   assign rd_shifted = bus.pmem_rdata >> shamt;

   always_comb begin
      load_data = '0;
      case (size_q)
         2'd0:    load_data = {56'd0, rd_shifted[7:0]};
         2'd1:    load_data = {48'd0, rd_shifted[15:0]};
         2'd2:    load_data = {32'd0, rd_shifted[31:0]};
         default: load_data = rd_shifted;
      endcase
   end

   // The access strobe is only high in the final WAIT cycle, so the memory sees exactly one
   // access per request, on the edge that enters RESP; reset drops it immediately.
   assign bus.pmem_en    = (state == WAIT) && (cnt == 5'd0) && !err_q;
   assign bus.pmem_we    = wr_q;
   assign bus.pmem_addr  = {addr_q[63:3], 3'b000};
   assign bus.pmem_wdata = wdata_q << shamt;
   assign bus.pmem_wmask = lane_mask[7:0] << offset;

   assign bus.Req_Ready  = (state == IDLE);
   assign bus.Resp_Valid = resp_valid_q;
   assign bus.Resp_RData = resp_rdata_q;
   assign bus.Resp_Err   = resp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         wr_q         <= 1'b0;
         size_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         err_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Req_Valid) begin
                  wr_q    <= bus.Req_Write;
                  size_q  <= bus.Req_Size;
                  addr_q  <= bus.Req_Addr;
                  wdata_q <= bus.Req_WData;
                  err_q   <= req_misalign || req_oor;
                  cnt     <= delay_load;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 5'd0) begin
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= err_q;
                  resp_rdata_q <= (err_q || wr_q) ? '0 : load_data;
                  state        <= RESP;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            RESP: begin
               if (bus.Resp_Ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder
//   Directed bench for pmem_responder (LATENCY=2). Provides a 16-word memory model on the
//   memory port, counts read/write accesses and records the last write.
module tb_pmem_responder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pmem_responder_if bus ();

   pmem_responder #(
      .LATENCY  (2),
      .ADDR_BASE(64'h8000_0000),
      .ADDR_SIZE(64'h0800_0000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [63:0] mem [16] = '{default: '0};
   int unsigned rd_calls = 0;
   int unsigned wr_calls = 0;
   logic [63:0] last_waddr = '0;
   logic [63:0] last_wdata = '0;
   logic [7:0]  last_wmask = '0;

   assign bus.pmem_rdata = mem[bus.pmem_addr[6:3]];

   always @(posedge clk) begin
      if (bus.pmem_en) begin
         if (bus.pmem_we) begin
            wr_calls   <= wr_calls + 1;
            last_waddr <= bus.pmem_addr;
            last_wdata <= bus.pmem_wdata;
            last_wmask <= bus.pmem_wmask;
            for (int b = 0; b < 8; b++)
               if (bus.pmem_wmask[b]) mem[bus.pmem_addr[6:3]][8*b +: 8] <= bus.pmem_wdata[8*b +: 8];
         end else begin
            rd_calls <= rd_calls + 1;
         end
      end
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request and waits for Resp_Valid; completes the handshake when Resp_Ready=1.
   task automatic xfer(input string tag, input logic wr, input logic [1:0] sz,
                       input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] rdata, output logic err);
      int lat;
      @(negedge clk);
      bus.Req_Valid = 1'b1;
      bus.Req_Write = wr;
      bus.Req_Size  = sz;
      bus.Req_Addr  = addr;
      bus.Req_WData = wd;
      chk({tag, "_ready"}, 64'(bus.Req_Ready), 64'd1);
      @(posedge clk);
      #1;
      bus.Req_Valid = 1'b0;
      lat = 0;
      while (!bus.Resp_Valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
`ifdef RANDOM_DELAY_EN
      chk({tag, "_lat_in_range"}, 64'((lat >= 2) && (lat <= 9)), 64'd1);
`else
      chk({tag, "_lat"}, 64'(lat), 64'd2);
`endif
      rdata = bus.Resp_RData;
      err   = bus.Resp_Err;
      if (bus.Resp_Ready) begin
         @(posedge clk);
         #1;
         chk({tag, "_valid_drop"}, 64'(bus.Resp_Valid), 64'd0);
         chk({tag, "_ready_back"}, 64'(bus.Req_Ready), 64'd1);
      end
   endtask

   initial begin
      logic [63:0] rd;
      logic        er;
      int unsigned rc, wc;

      bus.Req_Valid  = 1'b0;
      bus.Req_Write  = 1'b0;
      bus.Req_Size   = 2'd0;
      bus.Req_Addr   = '0;
      bus.Req_WData  = '0;
      bus.Resp_Ready = 1'b1;

      // Reset state
      #12;
      chk("rst_req_ready", 64'(bus.Req_Ready), 64'd1);
      chk("rst_resp_valid", 64'(bus.Resp_Valid), 64'd0);
      chk("rst_rdata", bus.Resp_RData, 64'd0);
      chk("rst_err", 64'(bus.Resp_Err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 8-byte store then load
      xfer("st8", 1'b1, 2'd3, 64'h8000_0000, 64'h1122_3344_5566_7788, rd, er);
      chk("st8_err", 64'(er), 64'd0);
      chk("st8_rdata", rd, 64'd0);
      chk("st8_wcalls", 64'(wr_calls), 64'd1);
      chk("st8_waddr", last_waddr, 64'h8000_0000);
      chk("st8_wmask", 64'(last_wmask), 64'hFF);
      xfer("ld8", 1'b0, 2'd3, 64'h8000_0000, '0, rd, er);
      chk("ld8_rdata", rd, 64'h1122_3344_5566_7788);
      chk("ld8_err", 64'(er), 64'd0);
      chk("ld8_rcalls", 64'(rd_calls), 64'd1);

      // Sub-word store/loads
      xfer("st1", 1'b1, 2'd0, 64'h8000_0003, 64'h0000_0000_0000_00AB, rd, er);
      chk("st1_waddr", last_waddr, 64'h8000_0000);
      chk("st1_wdata", last_wdata, 64'h0000_0000_AB00_0000);
      chk("st1_wmask", 64'(last_wmask), 64'h08);
      xfer("ld1", 1'b0, 2'd0, 64'h8000_0003, '0, rd, er);
      chk("ld1_rdata", rd, 64'h0000_0000_0000_00AB);
      xfer("ld2", 1'b0, 2'd1, 64'h8000_0002, '0, rd, er);
      chk("ld2_rdata", rd, 64'h0000_0000_0000_AB66);
      xfer("ld4", 1'b0, 2'd2, 64'h8000_0004, '0, rd, er);
      chk("ld4_rdata", rd, 64'h0000_0000_1122_3344);

      // Error cases and window boundaries
      rc = rd_calls;
      wc = wr_calls;
      xfer("mis4", 1'b0, 2'd2, 64'h8000_0002, '0, rd, er);
      chk("mis4_err", 64'(er), 64'd1);
      chk("mis4_rdata", rd, 64'd0);
      xfer("low1", 1'b0, 2'd0, 64'h0000_1000, '0, rd, er);
      chk("low1_err", 64'(er), 64'd1);
      xfer("top1", 1'b0, 2'd0, 64'h8800_0000, '0, rd, er);
      chk("top1_err", 64'(er), 64'd1);
      xfer("mis_st", 1'b1, 2'd1, 64'h8000_0001, 64'hFFFF, rd, er);
      chk("mis_st_err", 64'(er), 64'd1);
      chk("err_no_calls", 64'(rd_calls + wr_calls), 64'(rc + wc));
      xfer("last8", 1'b0, 2'd3, 64'h87FF_FFF8, '0, rd, er);
      chk("last8_err", 64'(er), 64'd0);
      chk("last8_rdata", rd, 64'd0);

      // Response stall; request inputs ignored outside IDLE
      bus.Resp_Ready = 1'b0;
      rc = rd_calls;
      wc = wr_calls;
      xfer("stall", 1'b0, 2'd3, 64'h8000_0000, '0, rd, er);
      chk("stall_rdata", rd, 64'h1122_3344_AB66_7788);
      @(negedge clk);
      bus.Req_Valid = 1'b1;
      bus.Req_Write = 1'b1;
      bus.Req_Size  = 2'd3;
      bus.Req_Addr  = 64'h8000_0000;
      bus.Req_WData = 64'hDEAD_BEEF_DEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", 64'(bus.Resp_Valid), 64'd1);
         chk("stall_hold", bus.Resp_RData, 64'h1122_3344_AB66_7788);
         chk("stall_req_ready", 64'(bus.Req_Ready), 64'd0);
      end
      bus.Req_Valid  = 1'b0;
      chk("stall_one_read", 64'(rd_calls), 64'(rc + 1));
      chk("stall_no_write", 64'(wr_calls), 64'(wc));
      bus.Resp_Ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_release_valid", 64'(bus.Resp_Valid), 64'd0);
      chk("stall_release_ready", 64'(bus.Req_Ready), 64'd1);

      // Reset during WAIT of a store
      wc = wr_calls;
      @(negedge clk);
      bus.Req_Valid = 1'b1;
      bus.Req_Write = 1'b1;
      bus.Req_Size  = 2'd3;
      bus.Req_Addr  = 64'h8000_0000;
      bus.Req_WData = 64'hCAFE_F00D_CAFE_F00D;
      @(posedge clk);
      #1;
      bus.Req_Valid = 1'b0;
      chk("rstw_in_wait", 64'(bus.Req_Ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("rstw_req_ready", 64'(bus.Req_Ready), 64'd1);
      chk("rstw_valid", 64'(bus.Resp_Valid), 64'd0);
      chk("rstw_rdata", bus.Resp_RData, 64'd0);
      chk("rstw_err", 64'(bus.Resp_Err), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rstw_no_write", 64'(wr_calls), 64'(wc));
      chk("rstw_ready_after", 64'(bus.Req_Ready), 64'd1);
      xfer("rstw_ld", 1'b0, 2'd3, 64'h8000_0000, '0, rd, er);
      chk("rstw_mem_intact", rd, 64'h1122_3344_AB66_7788);

`ifdef RANDOM_DELAY_EN
      rc = rd_calls;
      for (int i = 0; i < 100; i++) begin
         xfer("rnd", 1'b0, 2'd3, 64'h8000_0000, '0, rd, er);
         chk("rnd_rdata", rd, 64'h1122_3344_AB66_7788);
      end
      chk("rnd_calls", 64'(rd_calls), 64'(rc + 100));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
